// File: rtl/oled_fb_pkg.sv
// Shared types for the OLED framebuffer arbiter: RAM-port FSM states and default geometry.
package oled_fb_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRead    = 2'd1,
        StCapture = 2'd2
    } fb_state_e;

    localparam int unsigned FB_X_BITS     = 7;
    localparam int unsigned FB_Y_BITS     = 7;
    localparam int unsigned FB_COLOR_BITS = 16;

endpackage

// File: rtl/oled_fb_wfifo.sv
// Small register-based synchronous FIFO for camera pixels, with registered ready/empty flags.
module oled_fb_wfifo #(
    parameter int unsigned C_WIDTH = 30,
    parameter int unsigned C_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_valid,
    output logic               push_ready,
    input  logic [C_WIDTH-1:0] push_data,
    input  logic               pop,
    output logic               empty,
    output logic [C_WIDTH-1:0] head
);
    localparam int unsigned PtrBits = $clog2(C_DEPTH);
    localparam int unsigned CntBits = PtrBits + 1;

    logic [C_WIDTH-1:0] mem_q [C_DEPTH];
    logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] count_q, count_d;
    logic               ready_q, empty_q;
    logic               push, pop_ok;

    assign push   = push_valid & ready_q;
    assign pop_ok = pop & ~empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop_ok})
            2'b10:   count_d = count_q + CntBits'(1);
            2'b01:   count_d = count_q - CntBits'(1);
            default: count_d = count_q;
        endcase
    end

    // ready is !full, registered; it stays low during reset so no push can sneak in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != CntBits'(C_DEPTH));
            empty_q <= (count_d == '0);
            if (push)   wr_ptr_q <= wr_ptr_q + PtrBits'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PtrBits'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign push_ready = ready_q;
    assign empty      = empty_q;
    assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/oled_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads take priority, camera writes drain from a FIFO.
module oled_fb_arbiter
    import oled_fb_pkg::*;
#(
    parameter int unsigned C_X_BITS     = FB_X_BITS,
    parameter int unsigned C_Y_BITS     = FB_Y_BITS,
    parameter int unsigned C_COLOR_BITS = FB_COLOR_BITS,
    parameter int unsigned C_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [C_X_BITS-1:0]          disp_x,
    input  logic [C_Y_BITS-1:0]          disp_y,
    input  logic                         disp_next_pixel,
    output logic [C_COLOR_BITS-1:0]      disp_color,
    input  logic                         cam_valid,
    output logic                         cam_ready,
    input  logic [C_X_BITS-1:0]          cam_x,
    input  logic [C_Y_BITS-1:0]          cam_y,
    input  logic [C_COLOR_BITS-1:0]      cam_data,
    output logic [C_X_BITS+C_Y_BITS-1:0] fb_addr,
    output logic                         fb_we,
    output logic [C_COLOR_BITS-1:0]      fb_wdata,
    input  logic [C_COLOR_BITS-1:0]      fb_rdata,
    output logic                         frame_start
);
    localparam int unsigned AddrBits  = C_X_BITS + C_Y_BITS;
    localparam int unsigned EntryBits = AddrBits + C_COLOR_BITS;

    fb_state_e               state_q, state_d;
    logic                    rd_pending_q, rd_pending_d;
    logic [AddrBits-1:0]     rd_addr_q;
    logic [C_COLOR_BITS-1:0] disp_color_q;
    logic                    fifo_empty, wr_go;
    logic [EntryBits-1:0]    fifo_head;
    logic [C_X_BITS-1:0]     head_x;
    logic [C_Y_BITS-1:0]     head_y;
    logic [C_COLOR_BITS-1:0] head_data;

    oled_fb_wfifo #(
        .C_WIDTH(EntryBits),
        .C_DEPTH(C_FIFO_DEPTH)
    ) u_wfifo (
        .clk       (clk),
        .reset     (reset),
        .push_valid(cam_valid),
        .push_ready(cam_ready),
        .push_data ({cam_x, cam_y, cam_data}),
        .pop       (wr_go),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign {head_x, head_y, head_data} = fifo_head;

    // rd_pending resets high so pixel (0,0) is fetched straight after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            rd_pending_q <= 1'b1;
            rd_addr_q    <= '0;
            disp_color_q <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= rd_pending_d;
            if (disp_next_pixel) rd_addr_q <= {disp_y, disp_x};
            if (state_q == StCapture) disp_color_q <= fb_rdata;
        end
    end

    // A new request during READ re-arms the pending flag; the latest address wins.
    always_comb begin
        rd_pending_d = rd_pending_q;
        if (disp_next_pixel)        rd_pending_d = 1'b1;
        else if (state_q == StRead) rd_pending_d = 1'b0;

        state_d = state_q;
        unique case (state_q)
            StIdle:    if (rd_pending_q || disp_next_pixel) state_d = StRead;
            StRead:    state_d = StCapture;
            StCapture: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_go       = (state_q == StIdle) && !rd_pending_q && !fifo_empty;
        fb_we       = wr_go && !reset;
        fb_addr     = '0;
        fb_wdata    = '0;
        frame_start = (state_q == StRead) && (rd_addr_q == '0);
        if (state_q == StRead) begin
            fb_addr = rd_addr_q;
        end else if (wr_go) begin
            fb_addr  = {head_y, head_x};
            fb_wdata = head_data;
        end
    end

    assign disp_color = disp_color_q;

endmodule

// File: tb/tb_oled_fb_arbiter.sv
// Scoreboard bench for oled_fb_arbiter: random camera stream and display reads against a
// framebuffer model and an access-timing model of the arbiter.
module tb_oled_fb_arbiter;
    localparam int XB = 7;
    localparam int YB = 7;
    localparam int CB = 16;
    localparam int AB = XB + YB;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [XB-1:0] disp_x = '0;
    logic [YB-1:0] disp_y = '0;
    logic          disp_next_pixel = 1'b0;
    logic [CB-1:0] disp_color;
    logic          cam_valid = 1'b0;
    logic          cam_ready;
    logic [XB-1:0] cam_x = '0;
    logic [YB-1:0] cam_y = '0;
    logic [CB-1:0] cam_data = '0;
    logic [AB-1:0] fb_addr;
    logic          fb_we;
    logic [CB-1:0] fb_wdata;
    logic [CB-1:0] fb_rdata = '0;
    logic          frame_start;

    always #5 clk = ~clk;

    oled_fb_arbiter #(
        .C_X_BITS(XB), .C_Y_BITS(YB), .C_COLOR_BITS(CB), .C_FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .disp_x(disp_x), .disp_y(disp_y),
        .disp_next_pixel(disp_next_pixel), .disp_color(disp_color),
        .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_x(cam_x), .cam_y(cam_y),
        .cam_data(cam_data), .fb_addr(fb_addr), .fb_we(fb_we), .fb_wdata(fb_wdata),
        .fb_rdata(fb_rdata), .frame_start(frame_start)
    );

    typedef struct { logic [AB-1:0] addr; logic [CB-1:0] data; int due; } wr_exp_t;
    typedef struct { logic [AB-1:0] addr; int rd_cyc; int done_cyc; } rd_exp_t;

    logic [CB-1:0] ram      [1<<AB];
    logic [CB-1:0] fb_model [1<<AB];
    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t we;
    rd_exp_t rr;

    int  cyc = 0;
    int  n_pass = 0, n_chk = 0;
    int  last_done = 0;
    int  stall_run = 0, max_stall = 0;
    int  fs_seen = 0, fs_exp = 0;
    int  n_acc = 0, n0 = 0;
    int  cam_left = 0, seq_x = 0, seq_y = 0, t0 = 0, cnt = 0;
    bit  cam_seq = 0, lat_mode = 0, took = 0;

    initial begin
        for (int i = 0; i < (1 << AB); i++) begin
            ram[i]      = CB'(i) ^ 16'hA5A5;
            fb_model[i] = CB'(i) ^ 16'hA5A5;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fb_we) ram[fb_addr] <= fb_wdata;
        fb_rdata <= ram[fb_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Arbiter timing model: a request seen while idle is read next cycle, otherwise one
    // cycle after the access in flight finishes; colour is valid two cycles after the read.
    task automatic request(input int x, input int y);
        rd_exp_t it;
        disp_x          = XB'(x);
        disp_y          = YB'(y);
        disp_next_pixel = 1'b1;
        it.addr         = {YB'(y), XB'(x)};
        it.rd_cyc       = (cyc >= last_done) ? cyc + 1 : last_done + 1;
        it.done_cyc     = it.rd_cyc + 2;
        last_done       = it.done_cyc;
        rd_q.push_back(it);
        wait_cyc(1);
        disp_next_pixel = 1'b0;
    endtask

    task automatic release_reset();
        rd_exp_t it;
        reset       = 1'b0;
        it.addr     = '0;
        it.rd_cyc   = cyc + 1;
        it.done_cyc = cyc + 3;
        last_done   = it.done_cyc;
        rd_q.push_back(it);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_disp_color"}, 32'(disp_color), 32'd0);
        check({tag, "_cam_ready"}, 32'(cam_ready), 32'd0);
        check({tag, "_fb_we"}, 32'(fb_we), 32'd0);
        check({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
        check({tag, "_fb_wdata"}, 32'(fb_wdata), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0 || cam_left != 0 || cam_valid) && n < 300) begin
            wait_cyc(1);
            n++;
        end
        check("drain_within_budget", 32'(n < 300), 32'd1);
    endtask

    // Camera source: presents a new pixel once the previous one has been accepted.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            cam_valid = 1'b0;
        end else if (!cam_valid || took) begin
            if (cam_left > 0) begin
                cam_valid = 1'b1;
                if (cam_seq) begin
                    cam_x = XB'(seq_x);
                    cam_y = YB'(seq_y);
                    seq_x++;
                end else begin
                    cam_x = XB'($urandom_range(127, 0));
                    cam_y = YB'($urandom_range(127, 64));
                end
                cam_data = CB'($urandom);
                cam_left--;
            end else begin
                cam_valid = 1'b0;
            end
        end
        took = 1'b0;
    end

    // Handshake recorder: every accepted pixel becomes an expected RAM write.
    always @(negedge clk) begin
        if (!reset && cam_valid && cam_ready) begin
            wr_q.push_back('{addr: {cam_y, cam_x}, data: cam_data, due: lat_mode ? cyc + 1 : -1});
            n_acc++;
            took = 1'b1;
        end
    end

    // Monitor: compares RAM-port activity and disp_color against the scoreboard queues.
    always @(negedge clk) begin
        if (!reset) begin
            if (cam_valid && !cam_ready) stall_run++;
            else stall_run = 0;
            if (stall_run > max_stall) max_stall = stall_run;
            if (frame_start) fs_seen++;
            if (fb_we) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
                end else begin
                    we = wr_q.pop_front();
                    check("wr_addr", 32'(fb_addr), 32'(we.addr));
                    check("wr_data", 32'(fb_wdata), 32'(we.data));
                    if (we.due >= 0) check("wr_latency", 32'(cyc), 32'(we.due));
                    fb_model[we.addr] = we.data;
                end
            end
            if (rd_q.size() != 0) begin
                rr = rd_q[0];
                if (cyc == rr.rd_cyc) begin
                    check("rd_addr", 32'(fb_addr), 32'(rr.addr));
                    check("rd_we_low", 32'(fb_we), 32'd0);
                    check("rd_frame_start", 32'(frame_start), 32'(rr.addr == '0));
                    if (rr.addr == '0) fs_exp++;
                end
                if (cyc == rr.done_cyc) begin
                    check("disp_color", 32'(disp_color), 32'(fb_model[rr.addr]));
                    void'(rd_q.pop_front());
                end else if (cyc > rr.done_cyc) begin
                    check("rd_overdue", 32'(cyc), 32'(rr.done_cyc));
                    void'(rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then the automatic (0,0) fetch.
        wait_cyc(3);
        check_reset_outputs("reset");
        release_reset();
        wait_cyc(1);
        check("cam_ready_after_reset", 32'(cam_ready), 32'd1);
        wait_cyc(4);

        // Single display read at (5,2).
        request(5, 2);
        wait_cyc(4);

        // Six back-to-back camera pixels, row 9.
        lat_mode = 1;
        cam_seq  = 1;
        seq_x    = 0;
        seq_y    = 9;
        cam_left = 6;
        repeat (8) begin
            wait_cyc(1);
            check("burst_cam_ready", 32'(cam_ready), 32'd1);
        end
        drain();
        lat_mode = 0;
        cam_seq  = 0;

        // Continuous random stream with a display read every 32 cycles.
        max_stall = 0;
        cam_left  = 330;
        repeat (10) begin
            request($urandom_range(127, 0), $urandom_range(63, 16));
            wait_cyc(31);
        end
        drain();
        check("max_ready_stall", 32'(max_stall <= 2), 32'd1);

        // FIFO held full while reads keep the port busy.
        n0       = n_acc;
        cam_left = 12;
        request($urandom_range(127, 0), $urandom_range(63, 16));
        wait_cyc(1);
        repeat (4) begin
            request($urandom_range(127, 0), $urandom_range(63, 16));
            wait_cyc(2);
        end
        check("full_cam_ready", 32'(cam_ready), 32'd0);
        check("full_accepted", 32'(n_acc - n0), 32'(DEPTH));
        wait_cyc(1);
        check("drain1_cam_ready", 32'(cam_ready), 32'd0);
        wait_cyc(1);
        check("reopen_cam_ready", 32'(cam_ready), 32'd1);
        drain();

        // Reset during CAPTURE with three pixels queued to row 20.
        cam_seq  = 1;
        seq_x    = 1;
        seq_y    = 20;
        t0       = cyc;
        request(7, 30);
        cam_left = 3;
        wait_cyc(1);
        request(9, 31);
        wait_cyc(2);
        check("queued_before_reset", 32'(wr_q.size()), 32'd3);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        wr_q.delete();
        rd_q.delete();
        cam_left = 0;
        cam_seq  = 0;
        wait_cyc(2);
        release_reset();
        wait_cyc(6);
        request(1, 20);
        wait_cyc(4);
        request(3, 20);
        drain();

        check("frame_start_count", 32'(fs_seen), 32'(fs_exp));
        cnt = n_acc;
        check("pixels_accepted", 32'(cnt > 300), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
